// File: rtl/rr_arb_mux_pkg.sv
// Shared types, parameter limits and the circular priority search for rr_arb_mux.
package rr_arb_mux_pkg;

  typedef enum logic {StArb, StLock} arb_state_e;

  localparam int unsigned NMin   = 2;
  localparam int unsigned NMax   = 64;
  localparam int unsigned WMin   = 1;
  localparam int unsigned NIdxW  = $clog2(NMax);

  // First set bit of req[n-1:0], scanning ptr, ptr+1, ..., n-1, 0, ..., ptr-1.
  function automatic int unsigned rr_first_set(input logic [NMax-1:0] req,
                                               input int unsigned n,
                                               input int unsigned ptr);
    int unsigned idx;
    logic        found;
    rr_first_set = 0;
    found        = 1'b0;
    idx          = 0;
    for (int unsigned i = 0; i < NMax; i++) begin
      if (i < n) begin
        idx = ptr + i;
        if (idx >= n) idx = idx - n;
        if (!found && req[idx[NIdxW-1:0]]) begin
          found        = 1'b1;
          rr_first_set = idx;
        end
      end
    end
  endfunction

endpackage

// File: rtl/rr_arb_grant.sv
// Combinational round-robin grant: circular search from ptr, or a forced index when locked.
module rr_arb_grant
  import rr_arb_mux_pkg::*;
#(
  parameter int unsigned N = 8,
  localparam int unsigned SW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  input  logic          force_en,
  input  logic [SW-1:0] force_idx,
  output logic [N-1:0]  grant,
  output logic [SW-1:0] grant_idx,
  output logic          any
);

  logic [NMax-1:0] w_req_ext;
  int unsigned     w_idx;

  always_comb begin
    w_req_ext         = '0;
    w_req_ext[N-1:0]  = req;
    w_idx             = rr_first_set(w_req_ext, N, 32'(ptr));
    any               = |req;
    if (force_en) begin
      w_idx = 32'(force_idx);
      any   = req[force_idx];
    end
    grant_idx = SW'(w_idx);
    grant     = '0;
    if (any) grant[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/rr_arb_mux.sv
// N-channel round-robin arbitrating mux with a single registered output stage.
// Optional packet lock (in_last/out_last) is enabled by defining RR_ARB_MUX_LOCK_EN.
module rr_arb_mux
  import rr_arb_mux_pkg::*;
#(
  parameter int unsigned N = 8,
  parameter int unsigned W = 1,
  localparam int unsigned SW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N*W-1:0]  in_data,
  input  logic [N-1:0]    in_valid,
  output logic [N-1:0]    in_ready,
`ifdef RR_ARB_MUX_LOCK_EN
  input  logic [N-1:0]    in_last,
  output logic            out_last,
`endif
  output logic [W-1:0]    out_data,
  output logic [SW-1:0]   out_sel,
  output logic            out_valid,
  input  logic            out_ready
);

  if (N < NMin || N > NMax || W < WMin) begin : g_param_err
    $error("rr_arb_mux: N or W out of range");
  end

  logic [N-1:0]  w_grant;
  logic [SW-1:0] w_grant_idx;
  logic          w_any;
  logic          w_load_ok;
  logic          w_accept;
  logic          w_adv;
  logic          w_force_en;
  logic [SW-1:0] w_force_idx;
  logic [SW-1:0] w_ptr_next;
  logic [SW-1:0] r_ptr;
  logic [W-1:0]  r_out_data;
  logic [SW-1:0] r_out_sel;
  logic          r_out_valid;

  rr_arb_grant #(
    .N (N)
  ) u_grant (
    .req       (in_valid),
    .ptr       (r_ptr),
    .force_en  (w_force_en),
    .force_idx (w_force_idx),
    .grant     (w_grant),
    .grant_idx (w_grant_idx),
    .any       (w_any)
  );

  assign w_load_ok  = !r_out_valid || out_ready;
  assign w_accept   = w_any && w_load_ok;
  // rst_n gates ready so no source sees a handshake while reset is held.
  assign in_ready   = w_grant & {N{w_load_ok & rst_n}};
  assign w_ptr_next = (w_grant_idx == SW'(N - 1)) ? '0 : w_grant_idx + SW'(1);

`ifdef RR_ARB_MUX_LOCK_EN
  arb_state_e    r_state, w_state_d;
  logic [SW-1:0] r_lock_idx, w_lock_idx_d;
  logic          w_last;
  logic          r_out_last;

  assign w_last      = in_last[w_grant_idx];
  assign w_force_en  = (r_state == StLock);
  assign w_force_idx = r_lock_idx;
  assign w_adv       = w_accept && w_last;
  assign out_last    = r_out_last;

  always_comb begin
    w_state_d    = r_state;
    w_lock_idx_d = r_lock_idx;
    if (w_accept) begin
      if (w_last) begin
        w_state_d = StArb;
      end else begin
        w_state_d    = StLock;
        w_lock_idx_d = w_grant_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StArb;
      r_lock_idx <= '0;
      r_out_last <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_lock_idx <= w_lock_idx_d;
      if (w_accept) r_out_last <= w_last;
    end
  end
`else
  assign w_force_en  = 1'b0;
  assign w_force_idx = '0;
  assign w_adv       = w_accept;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sel   <= '0;
      r_ptr       <= '0;
    end else begin
      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_out_data  <= in_data[w_grant_idx*W +: W];
        r_out_sel   <= w_grant_idx;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (w_adv) r_ptr <= w_ptr_next;
    end
  end

  assign out_data  = r_out_data;
  assign out_sel   = r_out_sel;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed self-checking bench for rr_arb_mux (N=8, W=8); lock tests run with RR_ARB_MUX_LOCK_EN.
module tb_rr_arb_mux;

  localparam int unsigned N  = 8;
  localparam int unsigned W  = 8;
  localparam int unsigned SW = $clog2(N);

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_sel;
  logic           out_valid;
  logic           out_ready;
`ifdef RR_ARB_MUX_LOCK_EN
  logic [N-1:0]   in_last;
  logic           out_last;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  rr_arb_mux #(
    .N (N),
    .W (W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
`ifdef RR_ARB_MUX_LOCK_EN
    .in_last   (in_last),
    .out_last  (out_last),
`endif
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expect a beat from channel k on the output register.
  task automatic check_beat(input string tag, input int unsigned k);
    check({tag, " valid"}, 32'(out_valid), 32'd1);
    check({tag, " sel"}, 32'(out_sel), k);
    check({tag, " data"}, 32'(out_data), 32'h0A0 + k);
  endtask

  initial begin
    for (int k = 0; k < N; k++) in_data[k*W +: W] = W'(8'hA0 + k);
    rst_n     = 1'b0;
    in_valid  = '1;
    out_ready = 1'b1;
`ifdef RR_ARB_MUX_LOCK_EN
    in_last   = '0;
`endif

    // Reset with every channel valid.
    step();
    step();
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst in_ready", 32'(in_ready), 32'h00);
    check("rst out_sel", 32'(out_sel), 32'd0);
    check("rst out_data", 32'(out_data), 32'd0);
`ifdef RR_ARB_MUX_LOCK_EN
    check("rst out_last", 32'(out_last), 32'd0);
    in_last = '1;
`endif
    rst_n = 1'b1;
    #1;
    check("first grant", 32'(in_ready), 32'h01);

    // Fairness: 16 back-to-back beats 0..7,0..7.
    for (int i = 0; i < 16; i++) begin
      step();
      check_beat("fair", i % 8);
    end

    // Wrap and skip: move ptr to 6 via channel 5, then channels 2 and 7 only.
    in_valid = 8'h20;
    #1;
    check("ptr6 ready", 32'(in_ready), 32'h20);
    step();
    check_beat("ptr6 beat", 5);
    in_valid = 8'h84;
    #1;
    check("wrap ready a", 32'(in_ready), 32'h80);
    step();
    check_beat("wrap a", 7);
    check("wrap ready b", 32'(in_ready), 32'h04);
    step();
    check_beat("wrap b", 2);
    check("wrap ready c", 32'(in_ready), 32'h80);
    step();
    check_beat("wrap c", 7);

    // Drain, then backpressure on a beat from channel 3.
    in_valid = '0;
    step();
    check("drain valid", 32'(out_valid), 32'd0);
    in_valid  = 8'h08;
    out_ready = 1'b0;
    #1;
    check("bp ready empty", 32'(in_ready), 32'h08);
    step();
    check_beat("bp load", 3);
    in_valid = 8'h0A;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp ready held", 32'(in_ready), 32'h00);
      step();
      check_beat("bp hold", 3);
    end
    out_ready = 1'b1;
    #1;
    check("bp release ready", 32'(in_ready), 32'h02);
    step();
    check_beat("bp reload", 1);
    in_valid = '0;
    step();
    check("bp drain", 32'(out_valid), 32'd0);

`ifdef RR_ARB_MUX_LOCK_EN
    // Single-beat packet from channel 0 moves ptr to 1 and stays in ARB.
    in_valid = 8'h01;
    in_last  = 8'h01;
    #1;
    check("lk single ready", 32'(in_ready), 32'h01);
    step();
    check_beat("lk single", 0);
    check("lk single last", 32'(out_last), 32'd1);
    // Three-beat packet from channel 1 with channel 2 waiting.
    in_valid = 8'h06;
    in_last  = 8'h04;
    #1;
    check("lk ready 0", 32'(in_ready), 32'h02);
    step();
    check_beat("lk beat 0", 1);
    check("lk last 0", 32'(out_last), 32'd0);
    check("lk ready 1", 32'(in_ready), 32'h02);
    step();
    check_beat("lk beat 1", 1);
    in_last = 8'h06;
    #1;
    check("lk ready 2", 32'(in_ready), 32'h02);
    step();
    check_beat("lk beat 2", 1);
    check("lk last 2", 32'(out_last), 32'd1);
    check("lk ready ch2", 32'(in_ready), 32'h04);
    step();
    check_beat("lk ch2", 2);
    // Channel 1 opens a packet then drops valid: nobody else is granted.
    in_valid = 8'h02;
    in_last  = 8'h04;
    #1;
    check("stall open ready", 32'(in_ready), 32'h02);
    step();
    check_beat("stall open", 1);
    in_valid = 8'h04;
    #1;
    check("stall ready", 32'(in_ready), 32'h00);
    step();
    check("stall valid a", 32'(out_valid), 32'd0);
    step();
    check("stall valid b", 32'(out_valid), 32'd0);
    check("stall ready b", 32'(in_ready), 32'h00);
`endif

    // Mid-operation reset with a held beat (and, with lock, in LOCK state).
    in_valid = 8'h02;
    #1;
    check("pre rst ready", 32'(in_ready), 32'h02);
    step();
    check_beat("pre rst beat", 1);
    rst_n = 1'b0;
    #1;
    check("mid rst valid", 32'(out_valid), 32'd0);
    check("mid rst sel", 32'(out_sel), 32'd0);
    check("mid rst data", 32'(out_data), 32'd0);
    check("mid rst ready", 32'(in_ready), 32'h00);
`ifdef RR_ARB_MUX_LOCK_EN
    check("mid rst last", 32'(out_last), 32'd0);
`endif
    step();
    rst_n    = 1'b1;
    in_valid = 8'h04;
    #1;
    check("post rst ready", 32'(in_ready), 32'h04);
    step();
    check_beat("post rst beat", 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
